// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of a 4-digit 7-segment display between NSRC sources.
// One source word is latched per frame. Each digit slot starts with a short all-off gap.
module seg_display_scheduler #(
   parameter int NSRC      = 2,
   parameter int SCAN_DIV  = 131072,
   parameter int BLANK_CYC = 1024,
   parameter int DWELL     = 190
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NSRC-1:0]      src_valid,
   input  logic [16*NSRC-1:0]   src_data,
   output logic [3:0]           an,
   output logic [6:0]           seg,
   output logic [1:0]           active_src,
   output logic                 frame_tick
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DWELL + 1);

   typedef enum logic {BLANK, DRIVE} slot_e;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    digit_q, digit_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    act_q, act_d;
   logic [15:0]   word_q, word_d;
   logic          nv_q, nv_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   logic [3:0]    vld;
   logic          frame_start;
   logic          found;
   logic [1:0]    pick;
   int            idx;
   slot_e         slot;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'b1000000;
         4'h1: decode = 7'b1111001;
         4'h2: decode = 7'b0100100;
         4'h3: decode = 7'b0110000;
         4'h4: decode = 7'b0011001;
         4'h5: decode = 7'b0010010;
         4'h6: decode = 7'b0000010;
         4'h7: decode = 7'b1111000;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0010000;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b0000011;
         4'hC: decode = 7'b1000110;
         4'hD: decode = 7'b0100001;
         4'hE: decode = 7'b0000110;
         default: decode = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      vld              = '0;
      vld[NSRC-1:0]    = src_valid;
      frame_start      = (cnt_q == '0) && (digit_q == 2'd3);
      slot             = (cnt_q < CW'(BLANK_CYC)) ? BLANK : DRIVE;

      cnt_d   = (cnt_q == CW'(SCAN_DIV - 1)) ? '0 : cnt_q + 1'b1;
      digit_d = (cnt_q == CW'(SCAN_DIV - 1)) ? digit_q - 2'd1 : digit_q;

      act_d   = act_q;
      dwell_d = dwell_q;
      word_d  = word_q;
      nv_d    = nv_q;
      found   = 1'b0;
      pick    = act_q;
      idx     = 0;

      if (frame_start) begin
         if ((dwell_q < DW'(DWELL - 1)) && vld[act_q]) begin
            found   = 1'b1;
            dwell_d = dwell_q + 1'b1;
         end else begin
            dwell_d = '0;
            // k = NSRC lands back on the current source, so it is tried last
            for (int k = 1; k <= NSRC; k++) begin
               idx = (int'(act_q) + k) % NSRC;
               if (!found && vld[2'(idx)]) begin
                  found = 1'b1;
                  pick  = 2'(idx);
               end
            end
         end
         act_d = pick;
         nv_d  = !found;
         if (found) word_d = src_data[int'(pick)*16 +: 16];
      end

      // Use the word being latched so a zero-length blank still shows the new frame.
      if (slot == BLANK) begin
         an_d  = 4'b1111;
         seg_d = 7'b1111111;
      end else begin
         an_d  = ~(4'b0001 << digit_q);
         seg_d = nv_d ? 7'b0111111 : decode(word_d[int'(digit_q)*4 +: 4]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         digit_q <= 2'd3;
         dwell_q <= '0;
         act_q   <= '0;
         word_q  <= '0;
         nv_q    <= 1'b1;
         an_q    <= 4'b1111;
         seg_q   <= 7'b1111111;
      end else begin
         cnt_q   <= cnt_d;
         digit_q <= digit_d;
         dwell_q <= dwell_d;
         act_q   <= act_d;
         word_q  <= word_d;
         nv_q    <= nv_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign active_src = act_q;
   assign frame_tick = frame_start && !rst;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler: stimulus queues per-frame expectations,
// a monitor checks each frame's slots when frame_tick appears.
module tb_seg_display_scheduler;

   localparam int NF = 17;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  src_valid = 2'b00;
   logic [31:0] src_data = '0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic [1:0]  active_src;
   logic        frame_tick;

   seg_display_scheduler #(.NSRC(2), .SCAN_DIV(16), .BLANK_CYC(2), .DWELL(3)) dut (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
      .an(an), .seg(seg), .active_src(active_src), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  act;
      logic [15:0] word;
      bit          nv;
   } rec_t;

   rec_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   mon_en = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [3:0] an_tbl [4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // Hand-worked frame sequence with DWELL=3; inputs for frame i are applied during frame i-1.
   logic [1:0]  s_v  [NF] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
                              2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
   logic [15:0] s_d0 [NF] = '{16'h1A2F, 16'h1A2F, 16'h1A2F, 16'h0000, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h9ABC, 16'h9ABC,
                              16'h9ABC, 16'h9ABC, 16'h9ABC, 16'h0F0F, 16'h0F0F};
   logic [15:0] s_d1 [NF] = '{16'h0000, 16'h0000, 16'h0000, 16'h8888, 16'h8888, 16'h8888,
                              16'h8888, 16'h8888, 16'h8888, 16'h5678, 16'h5678, 16'hDEF0,
                              16'hDEF0, 16'hDEF0, 16'hC0DE, 16'hC0DE, 16'h7654};
   logic [1:0]  e_a  [NF] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0,
                              2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
   logic [15:0] e_w  [NF] = '{16'h1A2F, 16'h1A2F, 16'h1A2F, 16'h0000, 16'h0000, 16'h8888,
                              16'h8888, 16'h8888, 16'h0000, 16'h1234, 16'h9ABC, 16'hDEF0,
                              16'h0000, 16'h0000, 16'hC0DE, 16'h0F0F, 16'h7654};
   bit          e_nv [NF] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};

   task automatic chk(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (frame_tick) return;
      end
      chk("tick_timeout", 0, 1);
   endtask

   task automatic apply(input int i);
      rec_t r;
      src_valid      = s_v[i];
      src_data[15:0] = s_d0[i];
      src_data[31:16] = s_d1[i];
      r.act  = e_a[i];
      r.word = e_w[i];
      r.nv   = e_nv[i];
      q.push_back(r);
   endtask

   // Monitor: one frame = 64 cycles; outputs lag the counter by one cycle.
   initial begin
      rec_t r;
      bit   have_r;
      bit   have_last = 1'b0;
      int   last_tick = 0;
      int   s, j, d;
      logic [6:0] exp_seg;
      forever begin
         @(negedge clk);
         if (mon_en && frame_tick) begin
            if (have_last) chk("tick_gap", cyc - last_tick, 64);
            have_last = 1'b1;
            last_tick = cyc;
            have_r = (q.size() != 0);
            if (have_r) r = q.pop_front();
            else chk("sb_underflow", 0, 1);
            for (int o = 1; o < 64; o++) begin
               @(negedge clk);
               if (!have_r) continue;
               s = o / 16;
               j = o % 16;
               d = 3 - s;
               exp_seg = r.nv ? 7'h3F : dec_tbl[r.word[4*d +: 4]];
               if (o == 1) begin
                  chk("active_src", active_src, r.act);
                  chk("tick_low", frame_tick, 0);
               end
               if (j == 2) begin
                  chk("blank_an", an, 4'hF);
                  chk("blank_seg", seg, 7'h7F);
               end
               if (j == 3 || j == 15) begin
                  chk("drive_an", an, an_tbl[d]);
                  chk("drive_seg", seg, exp_seg);
               end
            end
         end
      end
   end

   initial begin
      apply(0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("rst_an", an, 4'hF);
         chk("rst_seg", seg, 7'h7F);
         chk("rst_act", active_src, 0);
         chk("rst_tick", frame_tick, 0);
      end
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 1; i < NF; i++) begin
         wait_tick();
         repeat (5) @(posedge clk);
         #1 apply(i);
      end
      wait_tick();
      repeat (62) @(negedge clk);
      mon_en = 1'b0;
      chk("sb_drain", q.size(), 0);

      // Reset pulse while digit 1 is being driven.
      wait_tick();
      repeat (38) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_an", an, 4'hF);
      chk("midrst_seg", seg, 7'h7F);
      chk("midrst_restart_tick", frame_tick, 1);
      repeat (3) @(negedge clk);
      chk("midrst_digit3", an, 4'b0111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
